// File: rtl/shift_rows_engine.sv
// Multi-cycle AES ShiftRows / InvShiftRows engine over a ROWS x NUM_COLS byte state.
// Rotates one row per clock; valid/ready on both sides.
// Optional feature macro: SHIFT_ROWS_INV_EN (honour invMode for right rotation).
module shift_rows_engine #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned NUM_COLS = 4,
    localparam int unsigned STATE_W = 8 * ROWS * NUM_COLS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [STATE_W-1:0] stateIn,
    input  logic               invMode,
    output logic               outValid,
    input  logic               outReady,
    output logic [STATE_W-1:0] stateOut,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    row_cnt_q, row_cnt_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [STATE_W-1:0] rot_state;

    // MSB position of byte (column c, row r); byte 0 is the MSB, column-major
    function automatic int unsigned msb(input int unsigned c, input int unsigned r);
        return STATE_W - 1 - 8 * (c * ROWS + r);
    endfunction

    // Source column for a left rotation of row r
    function automatic int unsigned src_left(input int unsigned c, input int unsigned r);
        return (c + r) % NUM_COLS;
    endfunction

`ifdef SHIFT_ROWS_INV_EN
    logic inv_q, inv_d;

    // Source column for a right rotation of row r
    function automatic int unsigned src_right(input int unsigned c, input int unsigned r);
        return (c + NUM_COLS - (r % NUM_COLS)) % NUM_COLS;
    endfunction
`else
    logic unused_inv_mode;
    assign unused_inv_mode = invMode;
`endif

    // Work register with only the row selected by row_cnt_q rotated
    always_comb begin
        rot_state = work_q;
        for (int unsigned r = 1; r < ROWS; r++) begin
            if (row_cnt_q == CntW'(r)) begin
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
`ifdef SHIFT_ROWS_INV_EN
                    if (inv_q) begin
                        rot_state[msb(c, r) -: 8] = work_q[msb(src_right(c, r), r) -: 8];
                    end else begin
                        rot_state[msb(c, r) -: 8] = work_q[msb(src_left(c, r), r) -: 8];
                    end
`else
                    rot_state[msb(c, r) -: 8] = work_q[msb(src_left(c, r), r) -: 8];
`endif
                end
            end
        end
    end

    // Next-state logic: accept in idle, one row per cycle, hold result until taken
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        work_d    = work_q;
`ifdef SHIFT_ROWS_INV_EN
        inv_d     = inv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (inValid) begin
                    work_d    = stateIn;
                    row_cnt_d = CntW'(1);
`ifdef SHIFT_ROWS_INV_EN
                    inv_d     = invMode;
`endif
                    // Row 0 never moves, so a single-row state is finished on accept
                    state_d   = (ROWS > 1) ? StRotate : StDone;
                end
            end
            StRotate: begin
                work_d    = rot_state;
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == CntW'(ROWS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (outReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            row_cnt_q <= '0;
            work_q    <= '0;
`ifdef SHIFT_ROWS_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            work_q    <= work_d;
`ifdef SHIFT_ROWS_INV_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign inReady  = (state_q == StIdle);
    assign outValid = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign stateOut = work_q;

endmodule

// File: tb/tb_shift_rows_engine.sv
// Self-checking bench for shift_rows_engine: 4x4 main instance plus 4x8 and 1x4 variants,
// checked against a row-queue reference model.
module tb_shift_rows_engine;

    typedef byte unsigned bq_t[$];

`ifdef SHIFT_ROWS_INV_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Main 4x4 instance
    logic         in_valid = 1'b0, in_ready, inv_mode = 1'b0;
    logic         out_valid, out_ready = 1'b0, busy;
    logic [127:0] state_in = '0, state_out;

    shift_rows_engine #(.ROWS(4), .NUM_COLS(4)) dut (
        .clk(clk), .reset(reset), .inValid(in_valid), .inReady(in_ready),
        .stateIn(state_in), .invMode(inv_mode), .outValid(out_valid),
        .outReady(out_ready), .stateOut(state_out), .busy(busy)
    );

    // 4x8 instance
    logic         p8_valid = 1'b0, p8_ready, p8_inv = 1'b0, p8_ovalid, p8_busy;
    logic [255:0] p8_in = '0, p8_out;

    shift_rows_engine #(.ROWS(4), .NUM_COLS(8)) dut48 (
        .clk(clk), .reset(reset), .inValid(p8_valid), .inReady(p8_ready),
        .stateIn(p8_in), .invMode(p8_inv), .outValid(p8_ovalid),
        .outReady(1'b1), .stateOut(p8_out), .busy(p8_busy)
    );

    // 1x4 instance
    logic        p1_valid = 1'b0, p1_ready, p1_inv = 1'b0, p1_ovalid, p1_busy;
    logic [31:0] p1_in = '0, p1_out;

    shift_rows_engine #(.ROWS(1), .NUM_COLS(4)) dut14 (
        .clk(clk), .reset(reset), .inValid(p1_valid), .inReady(p1_ready),
        .stateIn(p1_in), .invMode(p1_inv), .outValid(p1_ovalid),
        .outReady(1'b1), .stateOut(p1_out), .busy(p1_busy)
    );

    function automatic bq_t to_bytes(input logic [255:0] v, input int n);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(v[8*n-1-8*k -: 8]);
        return q;
    endfunction

    function automatic logic [255:0] from_bytes(input bq_t q, input int n);
        logic [255:0] v = '0;
        for (int k = 0; k < n; k++) v[8*n-1-8*k -: 8] = q[k];
        return v;
    endfunction

    // Reference: gather each row, spin it r mod cols times, scatter it back
    function automatic logic [255:0] model(input logic [255:0] v, input int rows, input int cols,
                                           input bit inv);
        bq_t s, o, row;
        s = to_bytes(v, rows * cols);
        o = s;
        for (int r = 0; r < rows; r++) begin
            row.delete();
            for (int c = 0; c < cols; c++) row.push_back(s[c*rows+r]);
            repeat (r % cols) begin
                if (inv && InvEn) row.push_front(row.pop_back());
                else row.push_back(row.pop_front());
            end
            for (int c = 0; c < cols; c++) o[c*rows+r] = row[c];
        end
        return from_bytes(o, rows * cols);
    endfunction

    // Push one block through the main instance; lat = edges from accept to outValid, -1 on timeout
    task automatic run_block(input logic [127:0] s, input bit inv,
                             output logic [127:0] res, output int lat);
        in_valid = 1'b1;
        state_in = s;
        inv_mode = inv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = state_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== '0) begin
            errors++;
            $display("FAIL reset: inReady=%b outValid=%b busy=%b stateOut=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, state_out);
        end
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int lat;
        run_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, res, lat);
        checks++;
        if (res !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
            errors++;
            $display("FAIL fips_fwd: got %h want d4bf5d30e0b452aeb84111f11e2798e5", res);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL fips_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] res, exp;
        int lat;
        exp = InvEn ? 128'hd42711aee0bf98f1b8b45de51e415230 :
                      model(256'(128'hd4bf5d30e0b452aeb84111f11e2798e5), 4, 4, 1'b0);
        run_block(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, res, lat);
        checks++;
        if (res !== exp || lat !== 3) begin
            errors++;
            $display("FAIL inverse: got %h lat %0d want %h lat 3", res, lat, exp);
        end
    endtask

    task automatic test_index();
        logic [127:0] res;
        int lat;
        run_block(128'h000102030405060708090a0b0c0d0e0f, 1'b0, res, lat);
        checks++;
        if (res !== 128'h00050a0f04090e03080d02070c01060b) begin
            errors++;
            $display("FAIL index: got %h want 00050a0f04090e03080d02070c01060b", res);
        end
    endtask

    task automatic test_random();
        logic [127:0] s, res, exp;
        bit inv;
        int lat;
        for (int i = 0; i < 40; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom % 2);
            exp = model(256'(s), 4, 4, inv)[127:0];
            run_block(s, inv, res, lat);
            checks++;
            if (res !== exp || lat !== 3) begin
                errors++;
                $display("FAIL random[%0d]: in %h inv %b got %h lat %0d want %h lat 3",
                         i, s, inv, res, lat, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, exp_a, exp_b;
        int lat;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        exp_a = model(256'(a), 4, 4, 1'b0)[127:0];
        exp_b = model(256'(b), 4, 4, 1'b1)[127:0];
        in_valid = 1'b1; state_in = a; inv_mode = 1'b0;
        @(posedge clk); #1;
        state_in = b; inv_mode = 1'b1;   // new block held while engine is busy
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || state_out !== exp_a || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: outValid=%b inReady=%b stateOut=%h want 1 0 %h",
                         i, out_valid, in_ready, state_out, exp_a);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: inReady=%b outValid=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (state_out !== exp_b || lat !== 3) begin
            errors++;
            $display("FAIL held_block: got %h lat %0d want %h lat 3", state_out, lat, exp_b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        in_valid = 1'b1;
        state_in = 128'h000102030405060708090a0b0c0d0e0f;
        inv_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: outValid=%b busy=%b stateOut=%h want 0 0 0",
                     out_valid, busy, state_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        run_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, res, lat);
        checks++;
        if (res !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || lat !== 3) begin
            errors++;
            $display("FAIL post_reset_block: got %h lat %0d want d4bf5d30e0b452aeb84111f11e2798e5",
                     res, lat);
        end
    endtask

    task automatic test_params();
        logic [255:0] v, exp;
        int n;
        for (int i = 0; i < 1000; i++) begin
            for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
            p8_in = v;
            p8_inv = 1'($urandom % 2);
            p8_valid = 1'b1;
            exp = model(v, 4, 8, p8_inv);
            @(posedge clk); #1;
            p8_valid = 1'b0;
            n = 0;
            while (!p8_ovalid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (p8_out !== exp || n !== 3) begin
                errors++;
                $display("FAIL p4x8[%0d]: got %h lat %0d want %h lat 3", i, p8_out, n, exp);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 1000; i++) begin
            p1_in = $urandom;
            p1_inv = 1'($urandom % 2);
            p1_valid = 1'b1;
            exp = model(256'(p1_in), 1, 4, p1_inv);
            @(posedge clk); #1;
            p1_valid = 1'b0;
            checks++;
            if (p1_ovalid !== 1'b1 || p1_out !== exp[31:0] || p1_out !== p1_in) begin
                errors++;
                $display("FAIL p1x4[%0d]: outValid=%b got %h want %h", i, p1_ovalid, p1_out,
                         exp[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #22 reset = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fips();
        test_inverse();
        test_index();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
